bin_to_bcd_seq: RTL
===================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 24, binary input width.
- DIGITS, 8, BCD output digit count.
REQ-002 Legal parameter values SHALL satisfy 10^DIGITS > 2^WIDTH-1; the defaults satisfy this (16,777,215 needs 8 digits).
REQ-003 Ports SHALL be, one per line (name  direction  width  meaning):
- CLK100MHZ  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  conversion request, sampled in IDLE only.
- bin_in  input  WIDTH  unsigned binary value, e.g. the SPI ADC sample.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd_out and blank updated.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- blank  output  DIGITS  leading-zero mask for the display stage; bit i high means digit i is a leading zero.

Function
REQ-004 Conversion SHALL use iterative shift-add-3 (double dabble), one input bit per clock, with no combinational division.
REQ-005 The state machine SHALL have three states: IDLE, SHIFT, DONE.
REQ-006 IDLE with start=1 at an edge:
- capture bin_in into an internal shift register;
- clear the BCD scratch register and the bit counter;
- go to SHIFT.
REQ-007 IDLE with start=0 SHALL stay in IDLE, with all outputs holding their values.
REQ-008 Each SHIFT cycle SHALL:
- add 3 to every scratch digit >= 5;
- shift {scratch, binary} left by one;
- increment the bit counter.
REQ-009 After exactly WIDTH SHIFT cycles, the FSM SHALL go to DONE.
REQ-010 DONE SHALL load bcd_out and blank from the final scratch value, assert done for that single cycle, and return to IDLE on the next edge.
REQ-011 Latency and timing:
- start sampled at edge k puts the FSM in SHIFT for edges k+1..k+WIDTH;
- DONE is entered at edge k+WIDTH;
- done is high during the cycle after edge k+WIDTH (25 cycles after the start sample for WIDTH=24).
REQ-012 busy SHALL equal (state != IDLE); it is high in every SHIFT and DONE cycle and low in IDLE.
REQ-013 start asserted while busy=1, including in the DONE cycle, SHALL be ignored and SHALL NOT be queued.
REQ-014 Maximum throughput SHALL be one conversion per WIDTH+2 cycles, with start held high continuously.
REQ-015 bcd_out and blank SHALL change only in the DONE cycle and SHALL hold their last values otherwise, so the display never sees a partial result.
REQ-016 blank generation:
- blank[i] = 1 if and only if digit i and all higher digits are zero, for i >= 1;
- blank[0] SHALL always be 0.
REQ-017 bin_in changes after capture SHALL NOT affect the conversion in progress.
REQ-018 All BCD digits of bcd_out SHALL be in the range 0-9 for every legal input.

Reset
REQ-019 While reset=1 at an edge, the block SHALL hold the following values:
- state IDLE, busy=0, done=0;
- bcd_out=0;
- blank = all ones except bit 0;
- internal registers cleared.
REQ-020 Reset SHALL take priority over start.
REQ-021 Reset asserted mid-conversion SHALL abort it with no done pulse; a start sampled in the first cycle after reset deasserts SHALL be accepted.

Verification
REQ-022 bin_in=0, start pulse -> done after 25 cycles, bcd_out=32'h00000000, blank=8'b11111110.
REQ-023 bin_in=24'hFFFFFF (16,777,215) -> bcd_out=32'h16777215, blank=8'b00000000.
REQ-024 bin_in=1234 -> bcd_out=32'h00001234, blank=8'b11110000; change bin_in to 9999 at cycle 5 -> result still 1234.
REQ-025 start held high continuously with bin_in=10, then 99 -> done pulses exactly 26 cycles apart; busy drops for exactly one cycle between conversions; start during busy causes no extra done.
REQ-026 Reset pulsed at cycle 12 of a conversion -> no done, bcd_out=0, busy=0 the next cycle; a new start of 500 yields bcd_out=32'h00000500.
REQ-027 10,000 random WIDTH-bit inputs -> bcd_out matches a reference decimal conversion and blank matches the leading-zero rule.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble),
// one input bit per clock, with a leading-zero blanking mask for the display.
module bin_to_bcd_seq #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned DIGITS = 8
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   shreg;
  logic [BCD_W-1:0]   scratch;
  logic [CNT_W-1:0]   cnt;

  logic               cnt_last_c;
  logic               capture_c;
  logic               shift_c;
  logic               load_c;
  logic [BCD_W-1:0]   adj_c;
  logic [BCD_W-1:0]   scratch_nxt_c;
  logic [DIGITS-1:0]  blank_nxt_c;
  logic               zero_run_c;

  assign cnt_last_c = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge CLK100MHZ) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_SHIFT;
      S_SHIFT: if (cnt_last_c) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath control strobes decoded from the current state
  always_comb begin
    capture_c = 1'b0;
    shift_c   = 1'b0;
    load_c    = 1'b0;
    case (state)
      S_IDLE:  capture_c = start;
      S_SHIFT: begin
        shift_c = 1'b1;
        load_c  = cnt_last_c;
      end
      default: ;
    endcase
  end

  // One double-dabble step: add 3 to digits >= 5, then shift in the next binary MSB
  always_comb begin
    adj_c = scratch;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    scratch_nxt_c = (adj_c << 1) | BCD_W'(shreg[WIDTH-1]);
  end

  // Leading-zero mask of the result being loaded; units digit is never blanked
  always_comb begin
    blank_nxt_c = '0;
    zero_run_c  = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run_c     = zero_run_c & (scratch_nxt_c[4*i +: 4] == 4'd0);
      blank_nxt_c[i] = zero_run_c;
    end
  end

  // Datapath and registered outputs; results only move when the last bit lands
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      blank   <= BLANK_RST;
    end else begin
      busy <= (state_next != S_IDLE);
      done <= (state_next == S_DONE);
      if (capture_c) begin
        shreg   <= bin_in;
        scratch <= '0;
        cnt     <= '0;
      end else if (shift_c) begin
        shreg   <= shreg << 1;
        scratch <= scratch_nxt_c;
        cnt     <= cnt + CNT_W'(1);
      end
      if (load_c) begin
        bcd_out <= scratch_nxt_c;
        blank   <= blank_nxt_c;
      end
    end
  end

endmodule
